// File: rtl/mul_operand_loader.sv
// Operand loader for the 2048-bit multiplier: assembles two operands from a word
// stream into shadow buffers and launches them as a pair with a one-cycle op_valid.
module mul_operand_loader #(
   parameter int DATA_WIDTH  = 2048,
   parameter int WORD_WIDTH  = 32,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WORD_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic [DATA_WIDTH-1:0] dat1,
   output logic [DATA_WIDTH-1:0] dat2,
   output logic                  op_valid,
   output logic                  busy,
   output logic                  err_len
);

   localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_cnt_nxt;
   logic             ready_q;
   logic             accept;
   logic             wr_a;
   logic             wr_b;
   logic             launch;
   logic             frame_err;

   logic [WORD_WIDTH-1:0] shadow_a [WORDS];
   logic [WORD_WIDTH-1:0] shadow_b [WORDS];
   logic [DATA_WIDTH-1:0] launch_a;
   logic [DATA_WIDTH-1:0] launch_b;

   assign accept  = s_valid && ready_q;
   assign s_ready = ready_q;
   assign busy    = (state == LOAD_B) || (state == HOLD) ||
                    ((state == LOAD_A) && (idx != '0));

   always_comb begin
      state_nxt    = state;
      idx_nxt      = idx;
      hold_cnt_nxt = hold_cnt;
      wr_a         = 1'b0;
      wr_b         = 1'b0;
      launch       = 1'b0;
      frame_err    = 1'b0;
      case (state)
         LOAD_A: begin
            if (accept) begin
               if (s_last) begin
                  // a pair can never end inside operand A
                  frame_err = 1'b1;
                  idx_nxt   = '0;
               end else begin
                  wr_a = 1'b1;
                  if (idx == IDX_LAST) begin
                     idx_nxt   = '0;
                     state_nxt = LOAD_B;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end
            end
         end
         LOAD_B: begin
            if (accept) begin
               wr_b = 1'b1;
               if (idx == IDX_LAST) begin
                  idx_nxt = '0;
                  if (s_last) begin
                     launch       = 1'b1;
                     hold_cnt_nxt = CNT_LOAD;
                     state_nxt    = HOLD;
                  end else begin
                     frame_err = 1'b1;
                     state_nxt = LOAD_A;
                  end
               end else if (s_last) begin
                  frame_err = 1'b1;
                  idx_nxt   = '0;
                  state_nxt = LOAD_A;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end
         end
         HOLD: begin
            if (hold_cnt == '0) begin
               state_nxt = LOAD_A;
            end else begin
               hold_cnt_nxt = hold_cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = LOAD_A;
            idx_nxt   = '0;
         end
      endcase
   end

   // The final word bypasses shadow_b and lands directly in dat2's top word.
   always_comb begin
      launch_a = '0;
      launch_b = '0;
      for (int k = 0; k < WORDS; k++) begin
         launch_a[k*WORD_WIDTH +: WORD_WIDTH] = shadow_a[k];
      end
      for (int k = 0; k < WORDS - 1; k++) begin
         launch_b[k*WORD_WIDTH +: WORD_WIDTH] = shadow_b[k];
      end
      launch_b[DATA_WIDTH-1 -: WORD_WIDTH] = s_data;
   end

   // ---- shadow buffers: data only, no reset ----
   always_ff @(posedge clk) begin
      if (wr_a) begin
         shadow_a[idx] <= s_data;
      end
      if (wr_b) begin
         shadow_b[idx] <= s_data;
      end
   end

   // ---- control state and launched operands ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOAD_A;
         idx      <= '0;
         hold_cnt <= '0;
         ready_q  <= 1'b0;
         op_valid <= 1'b0;
         err_len  <= 1'b0;
         dat1     <= '0;
         dat2     <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         hold_cnt <= hold_cnt_nxt;
         ready_q  <= (state_nxt != HOLD);
         op_valid <= launch;
         err_len  <= frame_err;
         if (launch) begin
            dat1 <= launch_a;
            dat2 <= launch_b;
         end
      end
   end

endmodule
